// File: rtl/fetch_sequencer.sv
// Fetch sequencer: host loads instruction memory in IDLE, then a run steps the
// fetch stage until the halt word or the watchdog ends it, with flush on redirect.
module fetch_sequencer #(
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic [7:0]  h_addr,
  input  logic [31:0] h_data,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        redirect,
  output logic        im_wea,
  output logic [7:0]  im_addr,
  output logic [31:0] im_din,
  output logic [1:0]  curr_state,
  output logic        ir_write,
  output logic        flush,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_cnt
);

  localparam int unsigned CNT_W        = 32;
  localparam logic [CNT_W-1:0] WDOG_LAST = MAX_CYCLES - 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_ir_write;
  logic             w_halt;
  logic             w_wdog;
  logic             r_flush;
  logic             r_done;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic             w_unused_pc;

  assign w_unused_pc = ^{pc[31:10], pc[1:0]};

  assign curr_state = r_state;
  assign ir_write   = w_ir_write;
  assign flush      = r_flush;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign cycle_cnt  = r_cycle_cnt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and memory-port muxing; IDLE values are the defaults (also used for 2'b11)
  always_comb begin
    w_next     = ST_IDLE;
    w_ir_write = 1'b0;
    w_halt     = 1'b0;
    w_wdog     = 1'b0;
    h_ready    = 1'b1;
    im_wea     = h_valid;
    im_addr    = h_addr;
    im_din     = h_data;
    case (r_state)
      ST_IDLE: begin
        w_next = start ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        h_ready    = 1'b0;
        im_wea     = 1'b0;
        im_din     = '0;
        im_addr    = pc[9:2];
        w_ir_write = !stall && !r_flush;
        w_halt     = w_ir_write && (instr == HALT_WORD);
        w_wdog     = !w_halt && (r_cycle_cnt == WDOG_LAST);
        w_next     = (w_halt || w_wdog) ? ST_HALT : ST_RUN;
      end
      ST_HALT: begin
        h_ready = 1'b0;
        im_wea  = 1'b0;
        im_din  = '0;
        im_addr = pc[9:2];
        w_next  = start ? ST_IDLE : ST_HALT;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Run bookkeeping: cycle counter, flush bubble and end-of-run flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_flush     <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_cycle_cnt <= '0;
      r_flush     <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      // The watchdog edge leaves the count at MAX_CYCLES-1; saturate instead of wrapping
      if (!w_wdog && (r_cycle_cnt != '1)) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      r_flush <= redirect && (w_next == ST_RUN);
      if (w_halt) begin
        r_done <= 1'b1;
      end
      if (w_wdog) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_flush <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: host load, runs, redirect/stall, watchdog, async reset.
module tb_fetch_sequencer;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        h_valid;
  logic        h_ready;
  logic [7:0]  h_addr;
  logic [31:0] h_data;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        redirect;
  logic        im_wea;
  logic [7:0]  im_addr;
  logic [31:0] im_din;
  logic [1:0]  curr_state;
  logic        ir_write;
  logic        flush;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] load_data [4] = '{32'h11, 32'h22, 32'h33, HW};

  fetch_sequencer #(.HALT_WORD(HW), .MAX_CYCLES(32'd8)) dut (
    .clk(clk), .rst(rst), .start(start), .h_valid(h_valid), .h_ready(h_ready),
    .h_addr(h_addr), .h_data(h_data), .pc(pc), .instr(instr), .stall(stall),
    .redirect(redirect), .im_wea(im_wea), .im_addr(im_addr), .im_din(im_din),
    .curr_state(curr_state), .ir_write(ir_write), .flush(flush), .done(done),
    .timeout(timeout), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic s, input logic r);
    pc = p; instr = i; stall = s; redirect = r;
    #1;
  endtask

  task automatic go_run();
    start = 1'b1;
    #1;
    tick();
    start = 1'b0;
  endtask

  task automatic leave_halt();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; h_valid = 1'b1; h_addr = 8'h0; h_data = 32'h0;
    pc = 32'h0; instr = 32'h0; stall = 1'b0; redirect = 1'b0;
    #3;
    checks++; if (curr_state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", curr_state); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cycle_cnt); end
    checks++; if ({done, timeout, flush} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {done, timeout, flush}); end
    checks++; if ({h_ready, ir_write, im_wea} !== 3'b101) begin errors++; $display("FAIL reset_comb got %b exp 101", {h_ready, ir_write, im_wea}); end
    h_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_host_load();
    for (int i = 0; i < 4; i++) begin
      h_valid = 1'b1; h_addr = 8'(i); h_data = load_data[i];
      #1;
      checks++; if ({h_ready, im_wea} !== 2'b11) begin errors++; $display("FAIL load_wea[%0d] got %b exp 11", i, {h_ready, im_wea}); end
      checks++; if (im_addr !== 8'(i)) begin errors++; $display("FAIL load_addr[%0d] got %0d exp %0d", i, im_addr, i); end
      checks++; if (im_din !== load_data[i]) begin errors++; $display("FAIL load_din[%0d] got %h exp %h", i, im_din, load_data[i]); end
      tick();
    end
    h_valid = 1'b0;
  endtask

  task automatic test_normal_run();
    h_valid = 1'b1; h_addr = 8'h05; h_data = 32'hAB;
    start = 1'b1;
    #1;
    checks++; if (im_wea !== 1'b1) begin errors++; $display("FAIL start_write got %b exp 1", im_wea); end
    tick();
    start = 1'b0; h_valid = 1'b0;
    checks++; if (curr_state !== 2'b01) begin errors++; $display("FAIL run_enter got %b exp 01", curr_state); end
    for (int i = 0; i < 4; i++) begin
      h_valid = (i == 1); start = (i == 2);
      drive(32'(i * 4), load_data[i], 1'b0, 1'b0);
      checks++; if (ir_write !== 1'b1) begin errors++; $display("FAIL run_irw[%0d] got %b exp 1", i, ir_write); end
      checks++; if ({im_addr, im_wea, h_ready} !== {8'(i), 2'b00}) begin errors++; $display("FAIL run_port[%0d] got %h exp %h", i, {im_addr, im_wea, h_ready}, {8'(i), 2'b00}); end
      tick();
      h_valid = 1'b0; start = 1'b0;
      if (i < 3) begin
        checks++; if ({curr_state, cycle_cnt} !== {2'b01, 32'(i + 1)}) begin errors++; $display("FAIL run_cnt[%0d] got %h exp %h", i, {curr_state, cycle_cnt}, {2'b01, 32'(i + 1)}); end
      end
    end
    checks++; if ({curr_state, done, timeout} !== 4'b1010) begin errors++; $display("FAIL run_halt got %b exp 1010", {curr_state, done, timeout}); end
    checks++; if (cycle_cnt !== 32'd4) begin errors++; $display("FAIL run_halt_cnt got %0d exp 4", cycle_cnt); end
    #1;
    checks++; if ({ir_write, flush} !== 2'b00) begin errors++; $display("FAIL halt_comb got %b exp 00", {ir_write, flush}); end
    tick();
    checks++; if ({curr_state, cycle_cnt} !== {2'b10, 32'd4}) begin errors++; $display("FAIL halt_hold got %h exp %h", {curr_state, cycle_cnt}, {2'b10, 32'd4}); end
    leave_halt();
    checks++; if ({curr_state, done, cycle_cnt} !== {2'b00, 1'b1, 32'd4}) begin errors++; $display("FAIL idle_hold got %h exp %h", {curr_state, done, cycle_cnt}, {2'b00, 1'b1, 32'd4}); end
  endtask

  task automatic test_redirect();
    go_run();
    checks++; if ({done, cycle_cnt} !== {1'b0, 32'd0}) begin errors++; $display("FAIL rd_clear got %h exp 0", {done, cycle_cnt}); end
    drive(32'd0, 32'h11, 1'b0, 1'b0);
    tick();
    drive(32'd4, 32'h22, 1'b0, 1'b1);
    checks++; if ({flush, ir_write} !== 2'b01) begin errors++; $display("FAIL rd_c2 got %b exp 01", {flush, ir_write}); end
    tick();
    drive(32'd8, HW, 1'b0, 1'b0);
    checks++; if ({flush, ir_write} !== 2'b10) begin errors++; $display("FAIL rd_c3 got %b exp 10", {flush, ir_write}); end
    tick();
    checks++; if (curr_state !== 2'b01) begin errors++; $display("FAIL rd_nohalt got %b exp 01", curr_state); end
    drive(32'd12, HW, 1'b0, 1'b0);
    checks++; if ({flush, ir_write} !== 2'b01) begin errors++; $display("FAIL rd_c4 got %b exp 01", {flush, ir_write}); end
    tick();
    checks++; if ({curr_state, done, cycle_cnt} !== {2'b10, 1'b1, 32'd4}) begin errors++; $display("FAIL rd_halt got %h exp %h", {curr_state, done, cycle_cnt}, {2'b10, 1'b1, 32'd4}); end
    leave_halt();
  endtask

  task automatic test_stall_flush();
    go_run();
    drive(32'd0, 32'h11, 1'b0, 1'b1);
    tick();
    drive(32'd4, HW, 1'b1, 1'b0);
    checks++; if ({flush, ir_write} !== 2'b10) begin errors++; $display("FAIL sf_k1 got %b exp 10", {flush, ir_write}); end
    tick();
    drive(32'd4, HW, 1'b1, 1'b0);
    checks++; if ({flush, ir_write} !== 2'b00) begin errors++; $display("FAIL sf_k2 got %b exp 00", {flush, ir_write}); end
    tick();
    checks++; if (curr_state !== 2'b01) begin errors++; $display("FAIL sf_nohalt got %b exp 01", curr_state); end
    drive(32'd4, HW, 1'b0, 1'b0);
    checks++; if ({flush, ir_write} !== 2'b01) begin errors++; $display("FAIL sf_k3 got %b exp 01", {flush, ir_write}); end
    tick();
    checks++; if ({curr_state, done, cycle_cnt} !== {2'b10, 1'b1, 32'd4}) begin errors++; $display("FAIL sf_halt got %h exp %h", {curr_state, done, cycle_cnt}, {2'b10, 1'b1, 32'd4}); end
    leave_halt();
  endtask

  task automatic test_redirect_held();
    logic exp_flush [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic redir [5]     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    go_run();
    for (int i = 0; i < 5; i++) begin
      drive(32'(i * 4), (i == 4) ? HW : 32'h0, 1'b0, redir[i]);
      checks++; if (flush !== exp_flush[i]) begin errors++; $display("FAIL held_flush[%0d] got %b exp %b", i, flush, exp_flush[i]); end
      tick();
    end
    checks++; if ({curr_state, done, cycle_cnt} !== {2'b10, 1'b1, 32'd5}) begin errors++; $display("FAIL held_halt got %h exp %h", {curr_state, done, cycle_cnt}, {2'b10, 1'b1, 32'd5}); end
    leave_halt();
  endtask

  task automatic test_watchdog();
    for (int pass = 0; pass < 2; pass++) begin
      go_run();
      checks++; if ({done, timeout} !== 2'b00) begin errors++; $display("FAIL wd_clear[%0d] got %b exp 00", pass, {done, timeout}); end
      for (int i = 0; i < 8; i++) begin
        drive(32'(i * 4), (pass == 1 && i == 7) ? HW : 32'h0, 1'b0, 1'b0);
        checks++; if ({curr_state, cycle_cnt} !== {2'b01, 32'(i)}) begin errors++; $display("FAIL wd_cnt[%0d.%0d] got %h exp %h", pass, i, {curr_state, cycle_cnt}, {2'b01, 32'(i)}); end
        tick();
      end
      if (pass == 0) begin
        checks++; if ({curr_state, done, timeout, cycle_cnt} !== {2'b10, 2'b01, 32'd7}) begin errors++; $display("FAIL wd_timeout got %h exp %h", {curr_state, done, timeout, cycle_cnt}, {2'b10, 2'b01, 32'd7}); end
        leave_halt();
        checks++; if ({curr_state, timeout} !== 3'b001) begin errors++; $display("FAIL wd_idle_hold got %b exp 001", {curr_state, timeout}); end
      end else begin
        checks++; if ({curr_state, done, timeout, cycle_cnt} !== {2'b10, 2'b10, 32'd8}) begin errors++; $display("FAIL wd_done_wins got %h exp %h", {curr_state, done, timeout, cycle_cnt}, {2'b10, 2'b10, 32'd8}); end
        leave_halt();
      end
    end
  endtask

  task automatic test_async_reset();
    go_run();
    drive(32'd0, 32'h11, 1'b0, 1'b1);
    tick();
    checks++; if ({flush, cycle_cnt} !== {1'b1, 32'd1}) begin errors++; $display("FAIL ar_pre got %h exp %h", {flush, cycle_cnt}, {1'b1, 32'd1}); end
    drive(32'd4, 32'h22, 1'b0, 1'b0);
    h_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({curr_state, flush, cycle_cnt} !== {2'b00, 1'b0, 32'd0}) begin errors++; $display("FAIL ar_async got %h exp 0", {curr_state, flush, cycle_cnt}); end
    checks++; if ({h_ready, ir_write, im_wea} !== 3'b101) begin errors++; $display("FAIL ar_comb got %b exp 101", {h_ready, ir_write, im_wea}); end
    #1;
    rst = 1'b0; h_valid = 1'b0;
    tick();
    checks++; if (curr_state !== 2'b00) begin errors++; $display("FAIL ar_post_edge got %b exp 00", curr_state); end
    go_run();
    checks++; if ({curr_state, cycle_cnt} !== {2'b01, 32'd0}) begin errors++; $display("FAIL ar_rerun got %h exp %h", {curr_state, cycle_cnt}, {2'b01, 32'd0}); end
    drive(32'd0, 32'h11, 1'b0, 1'b0);
    tick();
    drive(32'd4, HW, 1'b0, 1'b0);
    tick();
    checks++; if ({curr_state, done, cycle_cnt} !== {2'b10, 1'b1, 32'd2}) begin errors++; $display("FAIL ar_halt got %h exp %h", {curr_state, done, cycle_cnt}, {2'b10, 1'b1, 32'd2}); end
  endtask

  initial begin
    test_reset();
    test_host_load();
    test_normal_run();
    test_redirect();
    test_stall_flush();
    test_redirect_held();
    test_watchdog();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, the instruction word that ends a program run.
REQ-002 SHALL have parameter MAX_CYCLES, default 32'd100000, the watchdog limit on RUN cycles.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle pulse: IDLE->RUN, or HALT->IDLE.
REQ-006 h_valid  input  1  host write request to instruction memory.
REQ-007 h_ready  output  1  host write accepted when h_valid&&h_ready.
REQ-008 h_addr  input  8  host word address.
REQ-009 h_data  input  32  host write data.
REQ-010 pc  input  32  current PC from the fetch stage.
REQ-011 instr  input  32  instruction memory read data.
REQ-012 stall  input  1  downstream hazard; hold the IR.
REQ-013 redirect  input  1  jump/jal/jr/branch taken this cycle.
REQ-014 im_wea  output  1  instruction memory write enable.
REQ-015 im_addr  output  8  instruction memory address.
REQ-016 im_din  output  32  instruction memory write data.
REQ-017 curr_state  output  2  IDLE=2'b00, RUN=2'b01, HALT=2'b10.
REQ-018 ir_write  output  1  IR may load instr this cycle.
REQ-019 flush  output  1  current fetched word is wrong-path; insert bubble.
REQ-020 done  output  1  run finished on HALT_WORD.
REQ-021 timeout  output  1  run finished on watchdog.
REQ-022 cycle_cnt  output  32  RUN cycles elapsed in the current or last run.

Function
REQ-023 The FSM SHALL have states IDLE, RUN and HALT; encoding 2'b11 SHALL be treated as IDLE on the next edge.
REQ-024 In IDLE: h_ready=1; im_wea=h_valid; im_addr=h_addr; im_din=h_data; ir_write=0; flush=0.
REQ-025 In RUN and HALT: h_ready=0; im_wea=0; im_din=0; im_addr=pc[9:2].
REQ-026 IDLE->RUN on start. A same-cycle host write SHALL still complete.
REQ-027 On IDLE->RUN: cycle_cnt, done, timeout and the flush register SHALL clear to 0.
REQ-028 In RUN, cycle_cnt SHALL increment by 1 per cycle, with no wrap.
REQ-029 flush SHALL be a register set to 1 for exactly the one cycle after any RUN cycle with redirect=1.
REQ-030 A redirect held N consecutive cycles SHALL yield N consecutive flush cycles.
REQ-031 In RUN: ir_write = !stall && !flush.
REQ-032 In RUN, if flush=1 and stall=1 in the same cycle, the flush SHALL be consumed and SHALL not be re-asserted.
REQ-033 RUN->HALT with done=1 when ir_write=1 and instr==HALT_WORD.
REQ-034 A HALT_WORD seen while ir_write=0 (stalled or flushed) SHALL be ignored.
REQ-035 RUN->HALT with timeout=1 when cycle_cnt==MAX_CYCLES-1 and no halt is taken that cycle.
REQ-036 If the halt condition and the watchdog hit in the same cycle, done SHALL win and timeout SHALL stay 0.
REQ-037 In HALT: ir_write=0; flush=0; cycle_cnt frozen; done and timeout held.
REQ-038 HALT->IDLE on start; done, timeout and cycle_cnt SHALL be held until the next IDLE->RUN.
REQ-039 start in RUN SHALL be ignored. h_valid outside IDLE SHALL be ignored, with no write and no stored request.

Reset
REQ-040 On rst=1, immediately and independent of clk: state=IDLE, cycle_cnt=0, done=0, timeout=0, flush=0.
REQ-041 The combinational outputs SHALL follow the IDLE values during reset: h_ready=1, ir_write=0, im_wea=h_valid.
REQ-042 Reset asserted mid-RUN SHALL abort the run with no HALT entry. The first post-reset edge SHALL evaluate from IDLE.

Verification
REQ-043 Host load: in IDLE, write h_addr=0..3 with data 0x11,0x22,0x33,HALT_WORD -> im_wea=1, im_addr=h_addr, im_din=h_data each cycle; h_ready=1.
REQ-044 Normal run: start, then pc steps 0,4,8,12 with instr returning the loaded words -> curr_state=01; ir_write=1 for 4 cycles; on the HALT_WORD cycle next state=10, done=1, cycle_cnt=4.
REQ-045 Redirect: redirect=1 for one cycle at cycle 2 of RUN -> flush=1 and ir_write=0 at cycle 3 only; a HALT_WORD presented at cycle 3 SHALL not halt.
REQ-046 Stall and flush overlap: redirect at cycle k, stall=1 at cycles k+1..k+2 -> flush=1 at k+1 only; ir_write=0 at k+1..k+2 and 1 at k+3.
REQ-047 Watchdog: MAX_CYCLES=8, no HALT_WORD -> HALT after 8 RUN cycles with timeout=1, done=0, cycle_cnt=7. Same test with HALT_WORD at the 8th cycle -> done=1, timeout=0.
REQ-048 Async reset: assert rst between clock edges in RUN -> curr_state=00, cycle_cnt=0, flush=0 before the next edge. Then start -> RUN with cycle_cnt counting from 0.
